// File: rtl/clk_strobe_pkg.sv
// Shared types and constants for the clock strobe hub.
package clk_strobe_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int DIV_OFF   = 0;

    typedef struct packed {
        logic [DIV_W_DEF-1:0] div;
        logic                 cascade;
    } chan_cfg_t;

endpackage

// File: rtl/clk_strobe_chan.sv
// One hub channel: divide counter, shadow config, enable strobe and divided waveform.
module clk_strobe_chan
    import clk_strobe_pkg::*;
#(
    parameter int DIV_W           = DIV_W_DEF,
    parameter int DEFAULT_DIV     = 10,
    parameter bit DEFAULT_CASCADE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             restart_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    input  logic             wr_cascade_i,
    output logic             cascade_o,
    output logic             strobe_o,
    output logic             div_clk_o,
    output logic             pending_o
);

    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(DIV_OFF);
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d;
    logic             casc_q, casc_d;
    logic             sh_casc_q, sh_casc_d;
    logic             pend_q, pend_d;
    logic             strobe_q, strobe_d;
    logic             div_clk_q, div_clk_d;
    logic             enabled;
    logic             wrap;
    logic [DIV_W:0]   half;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        enabled   = (div_q != DIV_ZERO);
        wrap      = tick_i && enabled && (cnt_q == div_q - ONE);
        // Extra bit keeps (div+1)/2 exact at the largest divide ratio.
        half      = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
        cnt_d     = cnt_q;
        div_d     = div_q;
        casc_d    = casc_q;
        sh_div_d  = sh_div_q;
        sh_casc_d = sh_casc_q;
        pend_d    = pend_q;
        strobe_d  = 1'b0;
        div_clk_d = div_clk_q;

        if (restart_i) begin
            cnt_d = '0;
            if (wr_i) begin
                div_d  = wr_div_i;
                casc_d = wr_cascade_i;
            end else if (pend_q) begin
                div_d  = sh_div_q;
                casc_d = sh_casc_q;
            end
            pend_d    = 1'b0;
            div_clk_d = (div_d != DIV_ZERO);
        end else if (!enabled) begin
            cnt_d     = '0;
            div_clk_d = 1'b0;
            if (wr_i) begin
                div_d  = wr_div_i;
                casc_d = wr_cascade_i;
                pend_d = 1'b0;
            end
        end else begin
            if (tick_i) begin
                cnt_d     = wrap ? '0 : cnt_q + ONE;
                strobe_d  = wrap;
                div_clk_d = ({1'b0, cnt_d} < half);
            end
            if (wr_i) begin
                sh_div_d  = wr_div_i;
                sh_casc_d = wr_cascade_i;
                pend_d    = 1'b1;
            end
            // A write landing on the wrap edge itself is taken at that wrap.
            if (wrap && pend_d) begin
                div_d  = sh_div_d;
                casc_d = sh_casc_d;
                pend_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all channels update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            div_q     <= DIV_RST;
            casc_q    <= DEFAULT_CASCADE;
            // NOTE: shadow config is reset too, so a reset discards any pending write.
            sh_div_q  <= DIV_RST;
            sh_casc_q <= DEFAULT_CASCADE;
            pend_q    <= 1'b0;
            strobe_q  <= 1'b0;
            div_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            casc_q    <= casc_d;
            sh_div_q  <= sh_div_d;
            sh_casc_q <= sh_casc_d;
            pend_q    <= pend_d;
            strobe_q  <= strobe_d;
            div_clk_q <= div_clk_d;
        end
    end

    assign cascade_o = casc_q;
    assign strobe_o  = strobe_q;
    assign div_clk_o = div_clk_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/clk_strobe_hub.sv
// N-channel enable-strobe hub: config decode, cascade tick chain and channel array.
module clk_strobe_hub
    import clk_strobe_pkg::*;
#(
    parameter int N_CHAN          = 4,
    parameter int DIV_W           = DIV_W_DEF,
    parameter int DEFAULT_DIV     = 10,
    parameter bit DEFAULT_CASCADE = 1'b1,
    parameter int CHAN_W          = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHAN_W-1:0] cfg_chan,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_cascade,
    input  logic              sync_restart,
    output logic [N_CHAN-1:0] strobe,
    output logic [N_CHAN-1:0] div_clk,
    output logic [N_CHAN-1:0] cfg_pending
);

    logic              cfg_ready_q;
    logic              accept;
    logic [N_CHAN-1:0] cascade;
    logic [N_CHAN-1:0] prev_strobe;
    logic [N_CHAN-1:0] tick;
    logic [N_CHAN-1:0] wr;

    always_ff @(posedge clk) begin
        cfg_ready_q <= ~rst;
    end

    assign cfg_ready = cfg_ready_q;
    assign accept    = cfg_valid && cfg_ready_q;

    // Channel 0 sees a constant 1 upstream, so it always ticks regardless of its cascade bit.
    if (N_CHAN > 1) begin : g_chain
        assign prev_strobe = {strobe[N_CHAN-2:0], 1'b1};
    end else begin : g_single
        assign prev_strobe = 1'b1;
    end

    assign tick = ~cascade | prev_strobe;

    for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
        assign wr[i] = accept && (cfg_chan == CHAN_W'(i));

        clk_strobe_chan #(
            .DIV_W          (DIV_W),
            .DEFAULT_DIV    (DEFAULT_DIV),
            .DEFAULT_CASCADE(DEFAULT_CASCADE)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .tick_i      (tick[i]),
            .restart_i   (sync_restart),
            .wr_i        (wr[i]),
            .wr_div_i    (cfg_div),
            .wr_cascade_i(cfg_cascade),
            .cascade_o   (cascade[i]),
            .strobe_o    (strobe[i]),
            .div_clk_o   (div_clk[i]),
            .pending_o   (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_clk_strobe_hub.sv
// Scoreboard bench for clk_strobe_hub: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_clk_strobe_hub;
    import clk_strobe_pkg::*;

    localparam int N  = 4;
    localparam int DW = DIV_W_DEF;

    // Cycle landmarks (cycle n = state after the n-th rising edge).
    localparam int R  = 3;           // last reset edge
    localparam int T0 = R + 10010;   // a ch0 wrap edge with default div
    localparam int S  = T0 + 24;     // sync_restart edge (ch0 cnt = 3 just before)
    localparam int R2 = S + 83;      // last edge of the mid-run reset

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [1:0]   cfg_chan = '0;
    logic [DW-1:0] cfg_div = '0;
    logic         cfg_cascade = 1'b0;
    logic         sync_restart = 1'b0;
    logic [N-1:0] strobe;
    logic [N-1:0] div_clk;
    logic [N-1:0] cfg_pending;

    clk_strobe_hub #(
        .N_CHAN         (N),
        .DIV_W          (DW),
        .DEFAULT_DIV    (10),
        .DEFAULT_CASCADE(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_div     (cfg_div),
        .cfg_cascade (cfg_cascade),
        .sync_restart(sync_restart),
        .strobe      (strobe),
        .div_clk     (div_clk),
        .cfg_pending (cfg_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {K_STB, K_DCK, K_PND, K_RDY} kind_e;

    typedef struct {
        int           cyc;
        kind_e        kind;
        logic [N-1:0] mask;
        logic [N-1:0] val;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Keeps the scoreboard sorted by cycle.
    task automatic expect_at(input int c, input kind_e k, input logic [N-1:0] m,
                             input logic [N-1:0] v, input string nm);
        exp_t e;
        int   idx;
        e.cyc  = c;
        e.kind = k;
        e.mask = m;
        e.val  = v;
        e.name = nm;
        idx = sb.size();
        for (int j = 0; j < sb.size(); j++) begin
            if (sb[j].cyc > c) begin
                idx = j;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t         e;
        logic [N-1:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_STB:   act = strobe;
                K_DCK:   act = div_clk;
                K_PND:   act = cfg_pending;
                default: act = {{(N-1){1'b0}}, cfg_ready};
            endcase
            if (e.cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: sample for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
            end else begin
                check(e.name, act & e.mask, e.val);
            end
        end
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic chan_cfg_t mk(input int d, input bit c);
        chan_cfg_t r;
        r.div     = DW'(d);
        r.cascade = c;
        return r;
    endfunction

    // Presents one write so that it is sampled on edge e.
    task automatic write_cfg(input int e, input int ch, input chan_cfg_t c);
        goto(e - 1);
        cfg_valid   = 1'b1;
        cfg_chan    = ch[1:0];
        cfg_div     = c.div;
        cfg_cascade = c.cascade;
        goto(e);
        cfg_valid = 1'b0;
    endtask

    initial begin
        // Reset values and default cascade chain 10/100/1000/10000.
        expect_at(2, K_STB, 4'hF, 4'h0, "rst_strobe");
        expect_at(2, K_DCK, 4'hF, 4'h0, "rst_div_clk");
        expect_at(2, K_PND, 4'hF, 4'h0, "rst_pending");
        expect_at(2, K_RDY, 4'h1, 4'h0, "rst_ready");
        expect_at(R + 1, K_RDY, 4'h1, 4'h1, "ready_after_rst");
        expect_at(R + 1, K_DCK, 4'hF, 4'b0001, "dck_first");
        expect_at(R + 4, K_DCK, 4'b0001, 4'b0001, "dck0_hi_cnt4");
        expect_at(R + 5, K_DCK, 4'b0001, 4'b0000, "dck0_lo_cnt5");
        expect_at(R + 9, K_STB, 4'hF, 4'h0, "stb0_not_early");
        expect_at(R + 10, K_STB, 4'hF, 4'b0001, "stb0_first");
        expect_at(R + 11, K_DCK, 4'b0011, 4'b0011, "dck1_first_tick");
        expect_at(R + 100, K_STB, 4'hF, 4'b0001, "stb_100");
        expect_at(R + 101, K_STB, 4'hF, 4'b0010, "stb1_first");
        expect_at(R + 1001, K_STB, 4'hF, 4'b0010, "stb_1001");
        expect_at(R + 1002, K_STB, 4'hF, 4'b0100, "stb2_first");
        expect_at(R + 10000, K_STB, 4'hF, 4'b0001, "stb_10000");
        expect_at(R + 10001, K_STB, 4'hF, 4'b0010, "stb_10001");
        expect_at(R + 10002, K_STB, 4'hF, 4'b0100, "stb_10002");
        expect_at(R + 10003, K_STB, 4'hF, 4'b1000, "stb3_first");
        goto(R);
        rst = 1'b0;

        // ch0 retimed from 10 to 5 while running: takes effect at its next wrap.
        expect_at(T0 + 3, K_PND, 4'b0001, 4'b0001, "pend0_set");
        expect_at(T0 + 9, K_PND, 4'b0001, 4'b0001, "pend0_held");
        expect_at(T0 + 10, K_PND, 4'b0001, 4'b0000, "pend0_clr");
        expect_at(T0 + 10, K_STB, 4'b0001, 4'b0001, "stb0_old_wrap");
        expect_at(T0 + 12, K_DCK, 4'b0001, 4'b0001, "dck0_d5_hi");
        expect_at(T0 + 13, K_DCK, 4'b0001, 4'b0000, "dck0_d5_lo");
        expect_at(T0 + 14, K_DCK, 4'b0001, 4'b0000, "dck0_d5_lo2");
        expect_at(T0 + 14, K_STB, 4'b0001, 4'b0000, "stb0_d5_gap");
        expect_at(T0 + 15, K_STB, 4'b0001, 4'b0001, "stb0_d5_a");
        expect_at(T0 + 15, K_DCK, 4'b0001, 4'b0001, "dck0_d5_rise");
        expect_at(T0 + 20, K_STB, 4'b0001, 4'b0001, "stb0_d5_b");
        write_cfg(T0 + 3, 0, mk(5, 1'b0));

        // Pending writes for ch1/ch2, then sync_restart together with a ch0 write.
        expect_at(S - 1, K_PND, 4'b0110, 4'b0110, "pend12_set");
        expect_at(S - 1, K_DCK, 4'b0001, 4'b0000, "dck0_cnt3");
        expect_at(S, K_STB, 4'hF, 4'h0, "restart_stb");
        expect_at(S, K_DCK, 4'hF, 4'b1011, "restart_dck");
        expect_at(S, K_PND, 4'hF, 4'h0, "restart_pend");
        for (int k = 1; k <= 3; k++) begin
            expect_at(S + k, K_STB, 4'b0010, 4'b0010, "stb1_div1");
            expect_at(S + k, K_DCK, 4'b0010, 4'b0010, "dck1_div1");
        end
        expect_at(S + 3, K_STB, 4'b0001, 4'b0000, "stb0_d4_gap");
        expect_at(S + 4, K_STB, 4'b0001, 4'b0001, "stb0_d4_imm");
        expect_at(S + 1, K_STB, 4'b1100, 4'b0000, "stb23_off_a");
        expect_at(S + 20, K_STB, 4'b1100, 4'b0000, "stb23_off_b");
        expect_at(S + 20, K_DCK, 4'b1100, 4'b1000, "dck23_off");
        write_cfg(T0 + 21, 1, mk(1, 1'b0));
        write_cfg(T0 + 22, 2, mk(0, 1'b1));
        goto(S - 1);
        sync_restart = 1'b1;
        cfg_valid    = 1'b1;
        cfg_chan     = 2'd0;
        cfg_div      = DW'(4);
        cfg_cascade  = 1'b0;
        goto(S);
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;

        // Re-enable ch2 (immediate), then two writes to running ch0 (last wins).
        expect_at(S + 30, K_PND, 4'b0100, 4'b0000, "reen_no_pend");
        expect_at(S + 33, K_STB, 4'b0100, 4'b0000, "stb2_reen_gap");
        expect_at(S + 34, K_STB, 4'b0100, 4'b0100, "stb2_reen_a");
        expect_at(S + 38, K_STB, 4'b0100, 4'b0100, "stb2_reen_b");
        expect_at(S + 67, K_STB, 4'b1000, 4'b0000, "stb3_resume_gap");
        expect_at(S + 71, K_STB, 4'b1000, 4'b1000, "stb3_resume");
        expect_at(S + 41, K_PND, 4'b0001, 4'b0001, "pend0_b2b_a");
        expect_at(S + 43, K_PND, 4'b0001, 4'b0001, "pend0_b2b_b");
        expect_at(S + 44, K_PND, 4'b0001, 4'b0000, "pend0_b2b_clr");
        expect_at(S + 44, K_STB, 4'b0001, 4'b0001, "stb0_b2b_wrap");
        expect_at(S + 45, K_STB, 4'b0001, 4'b0000, "stb0_d2_gap");
        expect_at(S + 45, K_DCK, 4'b0001, 4'b0000, "dck0_d2_lo");
        expect_at(S + 46, K_STB, 4'b0001, 4'b0001, "stb0_d2_a");
        expect_at(S + 48, K_STB, 4'b0001, 4'b0001, "stb0_d2_b");
        write_cfg(S + 30, 2, mk(4, 1'b1));
        write_cfg(S + 41, 0, mk(7, 1'b0));
        write_cfg(S + 42, 0, mk(2, 1'b0));

        // Reset with a pending shadow and a concurrent write: defaults come back.
        expect_at(S + 80, K_PND, 4'b1000, 4'b1000, "pend3_set");
        expect_at(S + 81, K_PND, 4'b1000, 4'b1000, "pend3_held");
        for (int k = S + 82; k <= R2; k++) begin
            expect_at(k, K_STB, 4'hF, 4'h0, "rst2_strobe");
            expect_at(k, K_DCK, 4'hF, 4'h0, "rst2_div_clk");
            expect_at(k, K_PND, 4'hF, 4'h0, "rst2_pending");
            expect_at(k, K_RDY, 4'h1, 4'h0, "rst2_ready");
        end
        expect_at(R2 + 1, K_RDY, 4'h1, 4'h1, "rst2_ready_back");
        expect_at(R2 + 1, K_PND, 4'hF, 4'h0, "rst2_pend_clear");
        expect_at(R2 + 1, K_DCK, 4'hF, 4'b0001, "rst2_dck_defaults");
        expect_at(R2 + 3, K_STB, 4'b0001, 4'b0000, "rst2_no_div3");
        expect_at(R2 + 4, K_DCK, 4'b0001, 4'b0001, "rst2_dck0_hi");
        expect_at(R2 + 5, K_DCK, 4'b0001, 4'b0000, "rst2_dck0_lo");
        expect_at(R2 + 9, K_STB, 4'b0001, 4'b0000, "rst2_stb0_gap");
        expect_at(R2 + 10, K_STB, 4'b0001, 4'b0001, "rst2_stb0_div10");
        expect_at(R2 + 11, K_STB, 4'b0010, 4'b0000, "rst2_ch1_cascaded");
        write_cfg(S + 80, 3, mk(5, 1'b1));
        goto(S + 81);
        rst         = 1'b1;
        cfg_valid   = 1'b1;
        cfg_chan    = 2'd0;
        cfg_div     = DW'(3);
        cfg_cascade = 1'b0;
        goto(R2);
        rst       = 1'b0;
        cfg_valid = 1'b0;

        goto(R2 + 16);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: never sampled (due cycle %0d)", e.name, e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
